uart_tx_packet_sequencer: RTL and testbench
===========================================

Name: uart_tx_packet_sequencer

Overview:
- Upstream feeder for the UART transmitter. Accepts 2-byte sensor response packets (code byte, data byte) from the sensor controller into a small request FIFO.
- Serialises each packet byte by byte into the transmitter's byte-valid/done handshake.
- Enforces a configurable idle gap between packets.
- Decouples the sensor controller from UART bit timing so responses are never dropped while a byte is on the line.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries; power of two, at least 2.
- GAP_CLKS, 16, idle clocks inserted after a packet's last byte completes, before the next packet starts; 0 means no gap.

Ports:
- i_Clock  in  1  system clock
- i_Reset_n  in  1  synchronous active-low reset
- i_Req_Valid  in  1  request present
- i_Req_Code  in  8  response code byte (sent first)
- i_Req_Data  in  8  response data byte (sent second)
- o_Req_Ready  out  1  FIFO not full; request accepted when i_Req_Valid && o_Req_Ready
- o_Tx_DV  out  1  byte-valid to transmitter
- o_Tx_Byte  out  8  byte to transmitter; stable while o_Tx_DV is high
- i_Tx_Active  in  1  transmitter busy
- i_Tx_Done  in  1  transmitter done; may stay high for more than 1 cycle
- o_Busy  out  1  packet in flight or FIFO non-empty
- o_Pkt_Done  out  1  1-cycle pulse when a packet's second byte completes
- o_Overflow  out  1  sticky; set when i_Req_Valid is high while FIFO is full; cleared only by reset

Behaviour:
- Reset (sync, i_Reset_n=0 at a clock edge):
  - FIFO emptied; state to S_IDLE; gap counter and byte index cleared.
  - o_Tx_DV=0, o_Tx_Byte=0, o_Pkt_Done=0, o_Overflow=0, o_Busy=0, o_Req_Ready=1 after that edge.
  - Reset mid-packet abandons the packet; the downstream transmitter finishing its current byte is tolerated.
- FIFO:
  - 16-bit entries {code, data}; write and read pointers are log2(FIFO_DEPTH)+1 bits wide, with wrap on the MSB.
  - Full when pointers differ only in MSB; empty when equal.
  - Simultaneous push and pop when full: the push is refused (ready reflects the registered full state); the pop proceeds.
  - Simultaneous push and pop when empty: the push is stored and the pop does not occur that cycle.
- State machine:
  - S_IDLE: if FIFO non-empty and i_Tx_Active=0 and i_Tx_Done=0, pop the FIFO, latch the entry, set byte index to 0, go to S_SEND.
  - S_SEND: o_Tx_DV=1, o_Tx_Byte=code (index 0) or data (index 1). Hold until i_Tx_Active=1 is sampled, then drop DV and go to S_WAIT_DONE.
  - S_WAIT_DONE: wait for the i_Tx_Done rising edge (i_Tx_Done && !done_q). Then:
    - if index 0: set index to 1 and go to S_REARM;
    - else pulse o_Pkt_Done and go to S_GAP (or S_IDLE if GAP_CLKS=0).
  - S_REARM: wait until i_Tx_Done=0 and i_Tx_Active=0, then go to S_SEND. This prevents DV from being lost while the transmitter sits in its cleanup cycle.
  - S_GAP: count GAP_CLKS cycles, then go to S_IDLE.
- Latency:
  - Request accepted at cycle N into an empty FIFO with the transmitter idle: pop at N+1, o_Tx_DV high at N+2.
  - Byte 1 DV follows byte 0 done by 1–2 cycles, depending on S_REARM.
- Ordering: strict FIFO order; bytes never interleave between packets.
- o_Busy = (state != S_IDLE) || !empty.
- Spurious i_Tx_Done outside S_WAIT_DONE is ignored; done_q is still tracked every cycle.

Decomposition:
- Shared package uart_pkg: state encodings (S_IDLE..S_GAP), PKT_BYTES=2, packet entry width constant.
- One sub-module, sync_fifo: parameterised width and depth; ports push, pop, full, empty, dout. Registered-pointer, first-word-fall-through read.

Test Plan:
- Single packet: push {0x01,0x2A} with a transmitter model at CLKS_PER_BIT=4 → serial line shows 0x01 then 0x2A (LSB first); o_Pkt_Done pulses once; ≥GAP_CLKS idle before o_Busy falls.
- Back-to-back: push 4 packets {0x10+i, 0x20+i} in consecutive cycles → all 8 bytes emitted in order; o_Req_Ready stays 1 throughout; o_Overflow=0.
- Overflow: hold the transmitter busy and push 5 packets with FIFO_DEPTH=4 → 5th refused (o_Req_Ready=0); o_Overflow=1 and stays 1; the first 4 packets are still sent intact.
- Extended done: model holds i_Tx_Done high 2 cycles per byte → exactly 2 bytes per packet; no duplicate DV; byte 1 DV not asserted while i_Tx_Done=1.
- Reset mid-packet: deassert i_Reset_n one cycle during byte 0 of {0x55,0xAA} → next cycle o_Tx_DV=0, o_Busy=0, FIFO empty; a new packet {0x03,0x04} afterwards transmits correctly.
- GAP_CLKS=0 variant: two queued packets → byte 0 DV of the 2nd packet is asserted within 2 cycles of the 1st packet's o_Pkt_Done, once the transmitter is idle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART packet sequencer.
// A packet entry is {code, data}; the code byte sits in the upper half and goes out first.
package uart_pkg;

    localparam int PKT_BYTES = 2;
    localparam int BYTE_W    = 8;
    localparam int ENTRY_W   = PKT_BYTES * BYTE_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_DONE,
        S_REARM,
        S_GAP
    } state_t;

    function automatic logic [BYTE_W-1:0] entry_byte(input logic [ENTRY_W-1:0] entry,
                                                     input logic               idx);
        return idx ? entry[BYTE_W-1:0] : entry[ENTRY_W-1 -: BYTE_W];
    endfunction

endpackage

// File: rtl/uart_tx_packet_sequencer_if.sv
// Request channel from the sensor controller and byte handshake to the UART transmitter.
// master = sensor controller / transmitter side, slave = the sequencer.
interface uart_tx_packet_sequencer_if;
    import uart_pkg::*;

    logic              i_Req_Valid;
    logic [BYTE_W-1:0] i_Req_Code;
    logic [BYTE_W-1:0] i_Req_Data;
    logic              o_Req_Ready;
    logic              o_Tx_DV;
    logic [BYTE_W-1:0] o_Tx_Byte;
    logic              i_Tx_Active;
    logic              i_Tx_Done;

    modport master (
        output i_Req_Valid, i_Req_Code, i_Req_Data, i_Tx_Active, i_Tx_Done,
        input  o_Req_Ready, o_Tx_DV, o_Tx_Byte
    );

    modport slave (
        input  i_Req_Valid, i_Req_Code, i_Req_Data, i_Tx_Active, i_Tx_Done,
        output o_Req_Ready, o_Tx_DV, o_Tx_Byte
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read and registered pointers.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             i_Clock,
    input  logic             i_Reset_n,
    input  logic             i_Push,
    input  logic             i_Pop,
    input  logic [WIDTH-1:0] i_Din,
    output logic             o_Full,
    output logic             o_Empty,
    output logic [WIDTH-1:0] o_Dout
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_Wr_Ptr;
    logic [AW:0]      r_Rd_Ptr;
    logic [WIDTH-1:0] r_Mem [DEPTH];
    logic             w_Push_En;
    logic             w_Pop_En;

    assign o_Full    = (r_Wr_Ptr[AW] != r_Rd_Ptr[AW]) && (r_Wr_Ptr[AW-1:0] == r_Rd_Ptr[AW-1:0]);
    assign o_Empty   = (r_Wr_Ptr == r_Rd_Ptr);
    // Both qualifiers use the registered flags: a push into a full FIFO is refused
    // even if a pop happens in the same cycle, and a pop from empty never happens.
    assign w_Push_En = i_Push && !o_Full;
    assign w_Pop_En  = i_Pop && !o_Empty;
    assign o_Dout    = r_Mem[r_Rd_Ptr[AW-1:0]];

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_Wr_Ptr <= '0;
            r_Rd_Ptr <= '0;
        end else begin
            if (w_Push_En) r_Wr_Ptr <= r_Wr_Ptr + (AW+1)'(1);
            if (w_Pop_En)  r_Rd_Ptr <= r_Rd_Ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (w_Push_En) r_Mem[r_Wr_Ptr[AW-1:0]] <= i_Din;
    end

endmodule

// File: rtl/uart_tx_packet_sequencer.sv
// Queues 2-byte sensor response packets and feeds them byte by byte into the
// UART transmitter's DV/active/done handshake, with an idle gap between packets.
//
// state       | meaning
// S_IDLE      | waiting for a queued packet and an idle transmitter
// S_SEND      | o_Tx_DV held high until the transmitter reports active
// S_WAIT_DONE | byte on the line, waiting for the done rising edge
// S_REARM     | between bytes, waiting for done and active to clear
// S_GAP       | inter-packet idle gap down-count
module uart_tx_packet_sequencer
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CLKS   = 16
) (
    input  logic                             i_Clock,
    input  logic                             i_Reset_n,
    uart_tx_packet_sequencer_if.slave        bus,
    output logic                             o_Busy,
    output logic                             o_Pkt_Done,
    output logic                             o_Overflow
);

    localparam int                GAP_W    = (GAP_CLKS > 2) ? $clog2(GAP_CLKS) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD = (GAP_CLKS > 0) ? GAP_W'(GAP_CLKS - 1) : '0;

    state_t              r_State;
    logic [ENTRY_W-1:0]  r_Entry;
    logic                r_Byte_Idx;
    logic                r_Done_Q;
    logic                r_Tx_DV;
    logic [BYTE_W-1:0]   r_Tx_Byte;
    logic                r_Pkt_Done;
    logic                r_Overflow;
    logic [GAP_W-1:0]    r_Gap_Cnt;

    logic                w_Full;
    logic                w_Empty;
    logic                w_Pop;
    logic                w_Done_Rise;
    logic [ENTRY_W-1:0]  w_Fifo_Dout;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Push    (bus.i_Req_Valid),
        .i_Pop     (w_Pop),
        .i_Din     ({bus.i_Req_Code, bus.i_Req_Data}),
        .o_Full    (w_Full),
        .o_Empty   (w_Empty),
        .o_Dout    (w_Fifo_Dout)
    );

    // Only start a packet once the transmitter has fully finished any previous byte.
    assign w_Pop       = (r_State == S_IDLE) && !w_Empty && !bus.i_Tx_Active && !bus.i_Tx_Done;
    assign w_Done_Rise = bus.i_Tx_Done && !r_Done_Q;

    assign bus.o_Req_Ready = !w_Full;
    assign bus.o_Tx_DV     = r_Tx_DV;
    assign bus.o_Tx_Byte   = r_Tx_Byte;
    assign o_Busy          = (r_State != S_IDLE) || !w_Empty;
    assign o_Pkt_Done      = r_Pkt_Done;
    assign o_Overflow      = r_Overflow;

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_State    <= S_IDLE;
            r_Entry    <= '0;
            r_Byte_Idx <= 1'b0;
            r_Done_Q   <= 1'b0;
            r_Tx_DV    <= 1'b0;
            r_Tx_Byte  <= '0;
            r_Pkt_Done <= 1'b0;
            r_Overflow <= 1'b0;
            r_Gap_Cnt  <= '0;
        end else begin
            r_Done_Q   <= bus.i_Tx_Done;
            r_Pkt_Done <= 1'b0;
            if (bus.i_Req_Valid && w_Full) r_Overflow <= 1'b1;

            case (r_State)
                S_IDLE: begin
                    if (w_Pop) begin
                        r_Entry    <= w_Fifo_Dout;
                        r_Byte_Idx <= 1'b0;
                        r_Tx_Byte  <= entry_byte(w_Fifo_Dout, 1'b0);
                        r_Tx_DV    <= 1'b1;
                        r_State    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bus.i_Tx_Active) begin
                        r_Tx_DV <= 1'b0;
                        r_State <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (w_Done_Rise) begin
                        if (!r_Byte_Idx) begin
                            r_Byte_Idx <= 1'b1;
                            r_State    <= S_REARM;
                        end else begin
                            r_Pkt_Done <= 1'b1;
                            if (GAP_CLKS == 0) begin
                                r_State <= S_IDLE;
                            end else begin
                                r_Gap_Cnt <= GAP_LOAD;
                                r_State   <= S_GAP;
                            end
                        end
                    end
                end
                S_REARM: begin
                    if (!bus.i_Tx_Done && !bus.i_Tx_Active) begin
                        r_Tx_Byte <= entry_byte(r_Entry, r_Byte_Idx);
                        r_Tx_DV   <= 1'b1;
                        r_State   <= S_SEND;
                    end
                end
                S_GAP: begin
                    if (r_Gap_Cnt == '0) r_State <= S_IDLE;
                    else                 r_Gap_Cnt <= r_Gap_Cnt - GAP_W'(1);
                end
                default: r_State <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_packet_sequencer.sv
// Bench for uart_tx_packet_sequencer: a UART transmitter model (4 clocks per bit) with a
// serial-line decoder drives the main instance; a second GAP_CLKS=0 instance is hand-driven.
module tb_uart_tx_packet_sequencer;

    localparam int GAP = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_packet_sequencer_if bus();
    uart_tx_packet_sequencer_if bus2();

    logic busy, pkt_done, ovf;
    logic g0_busy, g0_done, g0_ovf;

    uart_tx_packet_sequencer #(.FIFO_DEPTH(4), .GAP_CLKS(GAP)) dut (
        .i_Clock(clk), .i_Reset_n(rst_n), .bus(bus),
        .o_Busy(busy), .o_Pkt_Done(pkt_done), .o_Overflow(ovf)
    );

    uart_tx_packet_sequencer #(.FIFO_DEPTH(4), .GAP_CLKS(0)) dut_g0 (
        .i_Clock(clk), .i_Reset_n(rst_n), .bus(bus2),
        .o_Busy(g0_busy), .o_Pkt_Done(g0_done), .o_Overflow(g0_ovf)
    );

    int checks = 0;
    int failures = 0;

    // transmitter model: 0 idle, 1 shifting start/data/stop, 2 done phase
    int         tm_st = 0;
    int         tm_cnt = 0;
    int         done_len = 1;
    logic [9:0] tm_frame = '1;
    logic       tm_active = 1'b0;
    logic       tm_done = 1'b0;
    logic       tm_serial = 1'b1;
    logic       hold_busy = 1'b0;

    assign bus.i_Tx_Active = tm_active | hold_busy;
    assign bus.i_Tx_Done   = tm_done;

    always @(posedge clk) begin
        case (tm_st)
            0: begin
                tm_serial <= 1'b1;
                tm_done   <= 1'b0;
                if (bus.o_Tx_DV) begin
                    tm_frame  <= {1'b1, bus.o_Tx_Byte, 1'b0};
                    tm_active <= 1'b1;
                    tm_serial <= 1'b0;
                    tm_cnt    <= 0;
                    tm_st     <= 1;
                end
            end
            1: begin
                if (tm_cnt == 39) begin
                    tm_active <= 1'b0;
                    tm_done   <= 1'b1;
                    tm_serial <= 1'b1;
                    tm_cnt    <= 0;
                    tm_st     <= 2;
                end else begin
                    tm_cnt    <= tm_cnt + 1;
                    tm_serial <= tm_frame[(tm_cnt + 1) / 4];
                end
            end
            default: begin
                if (tm_cnt + 1 >= done_len) begin
                    tm_done <= 1'b0;
                    tm_st   <= 0;
                end else begin
                    tm_cnt <= tm_cnt + 1;
                end
            end
        endcase
    end

    // serial decoder: sample mid-bit, LSB first
    logic [7:0] rx_q[$];
    initial begin
        logic [7:0] rx;
        forever begin
            @(negedge tm_serial);
            repeat (2) @(posedge clk);
            for (int b = 0; b < 8; b++) begin
                repeat (4) @(posedge clk);
                rx[b] = tm_serial;
            end
            rx_q.push_back(rx);
        end
    end

    int   dv_rises = 0;
    int   dv_done_overlap = 0;
    logic dv_q = 1'b0;
    always @(negedge clk) begin
        if (bus.o_Tx_DV && !dv_q) dv_rises++;
        if (bus.o_Tx_DV && bus.i_Tx_Done) dv_done_overlap++;
        dv_q = bus.o_Tx_DV;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    task automatic push_pkt(input logic [7:0] code, input logic [7:0] data);
        bus.i_Req_Valid = 1'b1;
        bus.i_Req_Code  = code;
        bus.i_Req_Data  = data;
        @(negedge clk);
        bus.i_Req_Valid = 1'b0;
    endtask

    task automatic wait_pkts(input string name, input int n, input int limit);
        int seen = 0;
        for (int i = 0; i < limit && seen < n; i++) begin
            @(negedge clk);
            if (pkt_done) seen++;
        end
        if (seen < n) timeout_fail(name);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy && tm_st == 0 && !tm_done) begin ok = 1; break; end
        end
        if (!ok) timeout_fail(name);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp[$]);
        check({name, "_count"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), 32'(rx_q[i]), 32'(exp[i]));
    endtask

    task automatic g0_serve(input string name, output logic [7:0] b);
        bit seen = 0;
        b = '0;
        for (int i = 0; i < 50; i++) begin
            if (bus2.o_Tx_DV) begin seen = 1; break; end
            @(negedge clk);
        end
        if (!seen) begin
            timeout_fail(name);
        end else begin
            b = bus2.o_Tx_Byte;
            bus2.i_Tx_Active = 1'b1;
            repeat (3) @(negedge clk);
            bus2.i_Tx_Active = 1'b0;
            bus2.i_Tx_Done   = 1'b1;
            @(negedge clk);
            bus2.i_Tx_Done   = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0] code;
        logic [7:0] data;
        int         dlen;
        logic [7:0] exp_b0;
        logic [7:0] exp_b1;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[4];
        logic [7:0] exp[$];
        logic [7:0] b;
        int         gap, extra, rises0, ready_low, cnt;

        vecs[0] = '{8'h01, 8'h2A, 1, 8'h01, 8'h2A};
        vecs[1] = '{8'hA5, 8'h3C, 2, 8'hA5, 8'h3C};
        vecs[2] = '{8'hFF, 8'h00, 2, 8'hFF, 8'h00};
        vecs[3] = '{8'h80, 8'h01, 1, 8'h80, 8'h01};

        bus.i_Req_Valid = 1'b0; bus.i_Req_Code = '0; bus.i_Req_Data = '0;
        bus2.i_Req_Valid = 1'b0; bus2.i_Req_Code = '0; bus2.i_Req_Data = '0;
        bus2.i_Tx_Active = 1'b0; bus2.i_Tx_Done = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_dv", 32'(bus.o_Tx_DV), 0);
        check("rst_byte", 32'(bus.o_Tx_Byte), 0);
        check("rst_pkt_done", 32'(pkt_done), 0);
        check("rst_overflow", 32'(ovf), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(bus.o_Req_Ready), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single packets, 1- and 2-cycle done
        for (int v = 0; v < 4; v++) begin
            done_len = vecs[v].dlen;
            rx_q.delete();
            rises0 = dv_rises;
            push_pkt(vecs[v].code, vecs[v].data);
            wait_pkts($sformatf("vec%0d_done", v), 1, 400);
            gap = 1; extra = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (!busy) break;
                gap++;
                if (pkt_done) extra++;
            end
            check($sformatf("vec%0d_gap", v), gap, GAP);
            check($sformatf("vec%0d_extra_pulse", v), extra, 0);
            wait_idle($sformatf("vec%0d_idle", v));
            exp = '{vecs[v].exp_b0, vecs[v].exp_b1};
            check_rx($sformatf("vec%0d", v), exp);
            check($sformatf("vec%0d_dv_rises", v), dv_rises - rises0, 2);
        end

        // back-to-back: four packets on consecutive cycles
        done_len = 1;
        rx_q.delete();
        ready_low = 0;
        exp.delete();
        for (int i = 0; i < 4; i++) begin
            if (!bus.o_Req_Ready) ready_low++;
            bus.i_Req_Valid = 1'b1;
            bus.i_Req_Code  = 8'h10 + 8'(i);
            bus.i_Req_Data  = 8'h20 + 8'(i);
            exp.push_back(8'h10 + 8'(i));
            exp.push_back(8'h20 + 8'(i));
            @(negedge clk);
        end
        bus.i_Req_Valid = 1'b0;
        wait_pkts("b2b_done", 4, 3000);
        wait_idle("b2b_idle");
        check_rx("b2b", exp);
        check("b2b_ready_low", ready_low, 0);
        check("b2b_overflow", 32'(ovf), 0);

        // overflow: transmitter held busy, fifth push refused
        hold_busy = 1'b1;
        rx_q.delete();
        exp.delete();
        ready_low = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("ovf_ready_full", 32'(bus.o_Req_Ready), 0);
            else if (!bus.o_Req_Ready) ready_low++;
            bus.i_Req_Valid = 1'b1;
            bus.i_Req_Code  = 8'h40 + 8'(i);
            bus.i_Req_Data  = 8'h50 + 8'(i);
            if (i < 4) begin
                exp.push_back(8'h40 + 8'(i));
                exp.push_back(8'h50 + 8'(i));
            end
            @(negedge clk);
        end
        bus.i_Req_Valid = 1'b0;
        check("ovf_ready_early", ready_low, 0);
        check("ovf_set", 32'(ovf), 1);
        repeat (10) @(negedge clk);
        check("ovf_sticky_hold", 32'(ovf), 1);
        hold_busy = 1'b0;
        wait_pkts("ovf_done", 4, 3000);
        wait_idle("ovf_idle");
        check_rx("ovf", exp);
        check("ovf_sticky_end", 32'(ovf), 1);

        // reset in the middle of byte 0
        rx_q.delete();
        push_pkt(8'h55, 8'hAA);
        cnt = 0;
        while (!tm_active && cnt < 50) begin @(negedge clk); cnt++; end
        if (!tm_active) timeout_fail("midrst_start");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_dv", 32'(bus.o_Tx_DV), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ready", 32'(bus.o_Req_Ready), 1);
        check("midrst_overflow", 32'(ovf), 0);
        rst_n = 1'b1;
        wait_idle("midrst_idle");
        check("midrst_no_restart", 32'(busy), 0);
        rx_q.delete();
        push_pkt(8'h03, 8'h04);
        wait_pkts("midrst_new_done", 1, 400);
        wait_idle("midrst_new_idle");
        exp = '{8'h03, 8'h04};
        check_rx("midrst_new", exp);

        // GAP_CLKS=0 instance, hand-driven transmitter
        bus2.i_Req_Valid = 1'b1; bus2.i_Req_Code = 8'h11; bus2.i_Req_Data = 8'h22;
        @(negedge clk);
        bus2.i_Req_Code = 8'h33; bus2.i_Req_Data = 8'h44;
        @(negedge clk);
        bus2.i_Req_Valid = 1'b0;
        g0_serve("g0_b0", b);  check("g0_byte0", 32'(b), 32'h11);
        g0_serve("g0_b1", b);  check("g0_byte1", 32'(b), 32'h22);
        check("g0_pkt1_done", 32'(g0_done), 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt++;
            if (bus2.o_Tx_DV) break;
        end
        check("g0_restart_within2", 32'(cnt <= 2 && bus2.o_Tx_DV), 1);
        g0_serve("g0_b2", b);  check("g0_byte2", 32'(b), 32'h33);
        g0_serve("g0_b3", b);  check("g0_byte3", 32'(b), 32'h44);
        check("g0_pkt2_done", 32'(g0_done), 1);
        @(negedge clk);
        check("g0_idle", 32'(g0_busy), 0);

        check("dv_during_done", dv_done_overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
